// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : mult_arbiter_if
// Brief  : Requester and response handshake bundle for mult_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
interface mult_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
);
  localparam int c_idw = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [2*WIDTH-1:0]    rsp_data;
  logic [c_idw-1:0]      rsp_id;
  logic                  busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mult_arbiter
// Brief  : Arbitrates NREQ requesters onto one shared multiplier through a
//          two-stage pipeline. MULT_ARB_RR_EN selects round-robin grant,
//          otherwise fixed priority (lowest index wins).
// Rev    : 1.0  initial release
// ============================================================================

module multiplication #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic [2*WIDTH-1:0] out
);
  assign out = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
endmodule

module mult_arbiter #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  mult_arbiter_if.slave  bus
);
  localparam int c_idw = $clog2(NREQ);

  logic [WIDTH-1:0]   r_s1_a;
  logic [WIDTH-1:0]   r_s1_b;
  logic [c_idw-1:0]   r_s1_id;
  logic               r_s1_valid;
  logic [2*WIDTH-1:0] r_s2_data;
  logic [c_idw-1:0]   r_s2_id;
  logic               r_s2_valid;

  logic               w_adv1;
  logic               w_adv2;
  logic               w_found;
  logic               w_accept;
  logic [NREQ-1:0]    w_grant;
  logic [c_idw-1:0]   w_grant_id;
  logic [c_idw-1:0]   w_idx;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;
  logic [2*WIDTH-1:0] w_prod;

  assign w_adv2 = !r_s2_valid | bus.rsp_ready;
  assign w_adv1 = !r_s1_valid | w_adv2;

`ifdef MULT_ARB_RR_EN
  logic [c_idw-1:0] r_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= c_idw'(NREQ - 1);
    end else if (w_accept) begin
      r_last <= w_grant_id;
    end
  end
`endif

  // First valid requester in search order wins; order starts after r_last
  // in round-robin mode, at index 0 in fixed-priority mode.
  always_comb begin
    w_grant    = '0;
    w_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef MULT_ARB_RR_EN
      w_idx = c_idw'((int'(r_last) + 1 + k) % NREQ);
`else
      w_idx = c_idw'(k);
`endif
      if (!w_found && bus.req_valid[w_idx]) begin
        w_found    = 1'b1;
        w_grant_id = w_idx;
      end
    end
    w_grant[w_grant_id] = w_found;
  end

  // Gating with rst_n keeps req_ready low while reset is held.
  assign bus.req_ready = w_grant & {NREQ{w_adv1 & rst_n}};
  assign w_accept      = w_found & w_adv1 & rst_n;

  assign w_sel_a = bus.req_a[int'(w_grant_id)*WIDTH +: WIDTH];
  assign w_sel_b = bus.req_b[int'(w_grant_id)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_id    <= '0;
      r_s1_valid <= 1'b0;
    end else if (w_accept) begin
      r_s1_a     <= w_sel_a;
      r_s1_b     <= w_sel_b;
      r_s1_id    <= w_grant_id;
      r_s1_valid <= 1'b1;
    end else if (w_adv1) begin
      r_s1_valid <= 1'b0;
    end
  end

  multiplication #(
    .WIDTH (WIDTH)
  ) u_mult (
    .in1 (r_s1_a),
    .in2 (r_s1_b),
    .out (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_data  <= '0;
      r_s2_id    <= '0;
      r_s2_valid <= 1'b0;
    end else if (w_adv2) begin
      r_s2_data  <= w_prod;
      r_s2_id    <= r_s1_id;
      r_s2_valid <= r_s1_valid;
    end
  end

  assign bus.rsp_valid = r_s2_valid;
  assign bus.rsp_data  = r_s2_data;
  assign bus.rsp_id    = r_s2_id;
  assign bus.busy      = r_s1_valid | r_s2_valid;

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter and two-stage pipeline controller that shares one `multiplication` datapath instance (WIDTH×WIDTH → 2·WIDTH, combinational) among NREQ requesters in the post-quantum accelerator math unit. It accepts operand pairs over per-requester valid/ready handshakes and registers the operands in stage 1. It drives the shared multiplier from stage 1 and registers the product in stage 2. It returns each product on a single tagged response port with backpressure.

## Interface
- WIDTH, 8, operand width; product width is 2·WIDTH
- NREQ, 4, number of requesters (≥2); IDW = $clog2(NREQ)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  bit i = requester i has an operand pair
- req_ready  out  NREQ  bit i = requester i's pair is accepted this cycle
- req_a  in  NREQ·WIDTH  requester i operand A at [i·WIDTH +: WIDTH]
- req_b  in  NREQ·WIDTH  requester i operand B at [i·WIDTH +: WIDTH]
- rsp_valid  out  1  rsp_data/rsp_id valid
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  2·WIDTH  product A·B, unsigned
- rsp_id  out  IDW  index of the originating requester
- busy  out  1  s1_valid | s2_valid

## Operation
- Stages: S1 (a, b, id, s1_valid), S2 (product, id, s2_valid). S1 feeds the shared `multiplication` instance: in1 = S1.a, in2 = S1.b.
- adv2 = !s2_valid | rsp_ready. adv1 = !s1_valid | adv2.
- Grant: one-hot among req_valid, computed combinationally. req_ready = grant & {NREQ{adv1}}. At most one bit of req_ready is set per cycle.
- Accept (req_valid[i] & req_ready[i]): S1 ← {req_a[i], req_b[i], i}, s1_valid ← 1.
- If adv1 and there is no accept, s1_valid ← 0.
- If adv2: S2 ← {multiplier out, S1.id}, s2_valid ← s1_valid.
- Round-robin: register `last` holds the most recently granted index. The search starts at last+1 mod NREQ and wraps. `last` updates only on an accept.
- Arithmetic: unsigned only, full 2·WIDTH product, no truncation or reduction.
- Requester rules: a/b must be held stable while valid & !ready. Dropping valid before ready is legal; the request is simply not taken.
- Outputs rsp_valid/rsp_data/rsp_id come straight from S2 registers. No combinational path from req_* to rsp_*.

## Timing
- Reset (async assert, sync-safe deassert): s1_valid = s2_valid = 0; S1/S2 data = 0; last = NREQ-1, so requester 0 wins first.
- Outputs during reset: rsp_valid = 0, rsp_data = 0, rsp_id = 0, busy = 0, req_ready = 0.
- Latency: accept on edge N → rsp_valid high after edge N+1, i.e. 2 cycles from req_valid&req_ready to rsp_valid with rsp_ready held high.
- Throughput: 1 accept/cycle sustained while rsp_ready = 1.
- Backpressure: rsp_valid & !rsp_ready holds S2 stable. S1 holds if full. req_ready drops to 0 the cycle both stages are full. No response is lost or duplicated.
- Simultaneous rsp handshake and new product: S2 reloads on the same edge.
- Simultaneous requests: exactly one grant per cycle; losers keep valid and are served later.
- Reset mid-operation: in-flight products are discarded; no rsp_valid until a new accept.

## Configuration
- MULT_ARB_RR_EN defined: round-robin grant as above.
- MULT_ARB_RR_EN undefined: fixed priority, lowest index wins. The `last` register is removed. All other behaviour and latency are identical.

## Test plan
- WIDTH=8. Req0 a=0x01 b=0x01 with rsp_ready=1 → rsp_valid 2 cycles later, rsp_data=0x0001, rsp_id=0; busy high for 2 cycles.
- Back-to-back on req2: (0x02,0x03), (0xF4,0x3D), (0x57,0x04) on consecutive cycles.
  - Responses on consecutive cycles: 0x0006, 0x3A24, 0x015C.
  - rsp_id=2 for all three.
- All 4 valid continuously:
  - With RR_EN: grants 0,1,2,3,0,1.
  - Without RR_EN: grants 0,0,0.
  - rsp_id sequence matches the grant sequence.
- Backpressure: stream on req1 with rsp_ready=0 for 3 cycles.
  - rsp_data stays frozen.
  - req_ready=0 once both stages are full.
  - After release, all products arrive in order, none lost or duplicated.
- Reset mid-flight: assert rst_n=0 one cycle after an accept.
  - rsp_valid=0, busy=0 immediately.
  - After release, the next accept yields the correct result 2 cycles later.
  - With RR_EN, requester 0 wins first.
- Max operands 0xFF×0xFF → 0xFE01; verify no truncation.
